// File: rtl/accel_tilt_conditioner.sv
// accel_tilt_conditioner: clamps, window-averages and dead-zone-filters X/Y accelerometer samples.
//   slowclk      in   sampling clock
//   reset_n      in   synchronous, active-low reset
//   sample_valid in   one-cycle strobe, data_x/data_y carry a new sample
//   data_x/y     in   raw signed samples
//   avg_x/y      out  windowed signed averages
//   dir_x/y      out  00 neutral, 01 positive, 10 negative
//   speed_x/y    out  0..SPEED_MAX, 0 exactly when neutral
//   out_valid    out  one-cycle strobe, outputs updated this cycle
module accel_tilt_conditioner #(
    parameter int DATA_W      = 16,
    parameter int AVG_LOG2    = 2,
    parameter int SAT         = 1023,
    parameter int DEAD_ON     = 128,
    parameter int DEAD_OFF    = 96,
    parameter int SPEED_SHIFT = 8,
    parameter int SPEED_MAX   = 3
) (
    input  logic              slowclk,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] data_x,
    input  logic [DATA_W-1:0] data_y,
    output logic [DATA_W-1:0] avg_x,
    output logic [DATA_W-1:0] avg_y,
    output logic [1:0]        dir_x,
    output logic [1:0]        dir_y,
    output logic [1:0]        speed_x,
    output logic [1:0]        speed_y,
    output logic              out_valid
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int FW    = AVG_LOG2 + 1;
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
    localparam logic [FW-1:0] FILL_LAST = FW'(DEPTH - 1);
    localparam logic signed [DATA_W-1:0] SAT_P = DATA_W'(SAT);
    localparam logic signed [DATA_W-1:0] ON_P  = DATA_W'(DEAD_ON);
    localparam logic signed [DATA_W-1:0] OFF_P = DATA_W'(DEAD_OFF);

    typedef enum logic [1:0] {NEUTRAL = 2'b00, POS = 2'b01, NEG = 2'b10} state_t;

    logic [FW-1:0] fill_q, fill_d;
    logic          upd_q, upd_d, out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] data_in [2];
    logic signed [DATA_W-1:0] avg_o [2];
    logic [1:0]               dir_o [2];
    logic [1:0]               spd_o [2];

    // Shared warm-up tracking: a pushed sample reaches stage 2 only once the window is full.
    always_comb begin
        fill_d      = (sample_valid && fill_q != FILL_FULL) ? fill_q + FW'(1) : fill_q;
        upd_d       = sample_valid && fill_q >= FILL_LAST;
        out_valid_d = upd_q;
    end

    always_ff @(posedge slowclk) begin
        if (!reset_n) begin
            fill_q      <= '0;
            upd_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            upd_q       <= upd_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_in[0] = data_x;
    assign data_in[1] = data_y;

    for (genvar a = 0; a < 2; a++) begin : g_axis
        logic signed [DATA_W-1:0] win_q [DEPTH];
        logic signed [DATA_W-1:0] win_d [DEPTH];
        logic signed [SUM_W-1:0]  sum_q, sum_d;
        logic signed [DATA_W-1:0] mean_q, mean_d, avg_q, avg_d, clamped;
        logic [DATA_W-1:0]        mag, raw_speed;
        logic [1:0]               speed_q, speed_d, speed_n;
        logic                     on_pos, on_neg;
        state_t                   state_q, state_d;

        always_comb begin
            clamped = data_in[a] > SAT_P ? SAT_P : (data_in[a] < -SAT_P ? -SAT_P : data_in[a]);
            win_d   = win_q;
            sum_d   = sum_q;
            mean_d  = mean_q;
            if (sample_valid) begin
                win_d[0] = clamped;
                for (int i = 1; i < DEPTH; i++) win_d[i] = win_q[i-1];
                sum_d  = sum_q + SUM_W'(clamped) - SUM_W'(win_q[DEPTH-1]);
                // Arithmetic shift floors negative averages toward -inf.
                mean_d = DATA_W'(sum_d >>> AVG_LOG2);
            end
            on_pos    = mean_q >= ON_P;
            on_neg    = mean_q <= -ON_P;
            mag       = mean_q[DATA_W-1] ? DATA_W'(-mean_q) : DATA_W'(mean_q);
            raw_speed = mag >> SPEED_SHIFT;
            speed_n   = raw_speed >= DATA_W'(SPEED_MAX) ? 2'(SPEED_MAX) :
                        (raw_speed == '0 ? 2'd1 : raw_speed[1:0]);
            state_d   = state_q;
            if (upd_q) begin
                unique case (state_q)
                    NEUTRAL: state_d = on_pos ? POS : (on_neg ? NEG : NEUTRAL);
                    POS:     state_d = on_neg ? NEG : (mean_q < OFF_P ? NEUTRAL : POS);
                    NEG:     state_d = on_pos ? POS : (mean_q > -OFF_P ? NEUTRAL : NEG);
                    default: state_d = NEUTRAL;
                endcase
            end
            speed_d = upd_q ? (state_d == NEUTRAL ? 2'd0 : speed_n) : speed_q;
            avg_d   = upd_q ? mean_q : avg_q;
        end

        always_ff @(posedge slowclk) begin
            if (!reset_n) begin
                win_q   <= '{default: '0};
                sum_q   <= '0;
                mean_q  <= '0;
                avg_q   <= '0;
                speed_q <= '0;
                state_q <= NEUTRAL;
            end else begin
                win_q   <= win_d;
                sum_q   <= sum_d;
                mean_q  <= mean_d;
                avg_q   <= avg_d;
                speed_q <= speed_d;
                state_q <= state_d;
            end
        end

        assign avg_o[a] = avg_q;
        assign dir_o[a] = state_q;
        assign spd_o[a] = speed_q;
    end

    assign avg_x     = avg_o[0];
    assign avg_y     = avg_o[1];
    assign dir_x     = dir_o[0];
    assign dir_y     = dir_o[1];
    assign speed_x   = spd_o[0];
    assign speed_y   = spd_o[1];
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_accel_tilt_conditioner.sv
// tb_accel_tilt_conditioner: directed vectors for the default and the no-averaging configuration.
module tb_accel_tilt_conditioner;
    logic        slowclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sv1, sv2;
    logic [15:0] x1, y1, x2, y2;
    logic [15:0] ax1, ay1, ax2, ay2;
    logic [1:0]  dx1, dy1, sx1, sy1, dx2, dy2, sx2, sy2;
    logic        ov1, ov2;
    logic [40:0] got1, got2, last1, last2;
    int          checks = 0;
    int          errors = 0;

    always #5 slowclk = ~slowclk;

    accel_tilt_conditioner dut1 (
        .slowclk(slowclk), .reset_n(reset_n), .sample_valid(sv1), .data_x(x1), .data_y(y1),
        .avg_x(ax1), .avg_y(ay1), .dir_x(dx1), .dir_y(dy1), .speed_x(sx1), .speed_y(sy1),
        .out_valid(ov1));

    accel_tilt_conditioner #(.AVG_LOG2(0)) dut2 (
        .slowclk(slowclk), .reset_n(reset_n), .sample_valid(sv2), .data_x(x2), .data_y(y2),
        .avg_x(ax2), .avg_y(ay2), .dir_x(dx2), .dir_y(dy2), .speed_x(sx2), .speed_y(sy2),
        .out_valid(ov2));

    assign got1 = {ov1, ax1, dx1, sx1, ay1, dy1, sy1};
    assign got2 = {ov2, ax2, dx2, sx2, ay2, dy2, sy2};

    typedef struct {
        logic [15:0] x, y;
        logic        v;
        logic [15:0] ax;
        logic [1:0]  dx, sx;
        logic [15:0] ay;
        logic [1:0]  dy, sy;
    } vec_t;

    function automatic vec_t mk(int x, int y, int v, int ax, int dx, int sx, int ay, int dy, int sy);
        vec_t r;
        r.x = 16'(x); r.y = 16'(y); r.v = 1'(v);
        r.ax = 16'(ax); r.dx = 2'(dx); r.sx = 2'(sx);
        r.ay = 16'(ay); r.dy = 2'(dy); r.sy = 2'(sy);
        return r;
    endfunction

    function automatic logic [40:0] pack(vec_t r);
        return {r.v, r.ax, r.dx, r.sx, r.ay, r.dy, r.sy};
    endfunction

    task automatic check(input string name, input logic [40:0] got, input logic [40:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    // Called on a falling edge; drives one sample, checks the idle cycle and the strobe cycle.
    task automatic run_vec(input vec_t r, input bit alt, input string name);
        logic [40:0] prev, exp;
        prev = alt ? last2 : last1;
        if (alt) begin sv2 = 1'b1; x2 = r.x; y2 = r.y; end
        else     begin sv1 = 1'b1; x1 = r.x; y1 = r.y; end
        @(negedge slowclk);
        sv1 = 1'b0; sv2 = 1'b0;
        check({name, "/hold"}, alt ? got2 : got1, {1'b0, prev[39:0]});
        @(negedge slowclk);
        exp = r.v ? pack(r) : {1'b0, prev[39:0]};
        check(name, alt ? got2 : got1, exp);
        if (alt) last2 = exp; else last1 = exp;
    endtask

    vec_t t1[17];
    vec_t t2[7];
    vec_t bb[6];

    initial begin
        t1[0]  = mk(200, -200, 0, 0, 0, 0, 0, 0, 0);
        t1[1]  = mk(200, -200, 0, 0, 0, 0, 0, 0, 0);
        t1[2]  = mk(200, -200, 0, 0, 0, 0, 0, 0, 0);
        t1[3]  = mk(200, -200, 1, 200, 1, 1, -200, 2, 1);
        t1[4]  = mk(100, -100, 1, 175, 1, 1, -175, 2, 1);
        t1[5]  = mk(100, -100, 1, 150, 1, 1, -150, 2, 1);
        t1[6]  = mk(100, -100, 1, 125, 1, 1, -125, 2, 1);
        t1[7]  = mk(100, -100, 1, 100, 1, 1, -100, 2, 1);
        t1[8]  = mk(80, -80, 1, 95, 0, 0, -95, 0, 0);
        t1[9]  = mk(32767, -32768, 1, 325, 1, 1, -326, 2, 1);
        t1[10] = mk(32767, -32768, 1, 556, 1, 2, -557, 2, 2);
        t1[11] = mk(32767, -32768, 1, 787, 1, 3, -788, 2, 3);
        t1[12] = mk(32767, -32768, 1, 1023, 1, 3, -1023, 2, 3);
        t1[13] = mk(-32768, 32767, 1, 511, 1, 1, -512, 2, 2);
        t1[14] = mk(-32768, 32767, 1, 0, 0, 0, 0, 0, 0);
        t1[15] = mk(-32768, 32767, 1, -512, 2, 2, 511, 1, 1);
        t1[16] = mk(-32768, 32767, 1, -1023, 2, 3, 1023, 1, 3);

        t2[0] = mk(300, 128, 1, 300, 1, 1, 128, 1, 1);
        t2[1] = mk(-300, 96, 1, -300, 2, 1, 96, 1, 1);
        t2[2] = mk(127, 95, 1, 127, 0, 0, 95, 0, 0);
        t2[3] = mk(128, -127, 1, 128, 1, 1, -127, 0, 0);
        t2[4] = mk(-128, -128, 1, -128, 2, 1, -128, 2, 1);
        t2[5] = mk(-96, -95, 1, -96, 2, 1, -95, 0, 0);
        t2[6] = mk(32767, -32768, 1, 1023, 1, 3, -1023, 2, 3);

        bb[0] = mk(900, -900, 1, 600, 1, 2, -600, 2, 2);
        bb[1] = mk(900, -900, 1, 700, 1, 2, -700, 2, 2);
        bb[2] = mk(900, -900, 1, 800, 1, 3, -800, 2, 3);
        bb[3] = mk(900, -900, 1, 900, 1, 3, -900, 2, 3);
        bb[4] = mk(900, -900, 1, 900, 1, 3, -900, 2, 3);
        bb[5] = mk(900, -900, 1, 900, 1, 3, -900, 2, 3);

        sv1 = 1'b0; sv2 = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        last1 = '0; last2 = '0;
        repeat (2) @(negedge slowclk);
        check("reset/dut1", got1, '0);
        check("reset/dut2", got2, '0);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(t1[i], 1'b0, $sformatf("t1[%0d]", i));
        for (int i = 0; i < 7; i++)  run_vec(t2[i], 1'b1, $sformatf("t2[%0d]", i));

        // Reset with a coinciding sample: everything clears and the sample is dropped.
        reset_n = 1'b0; sv1 = 1'b1; x1 = 16'(500); y1 = 16'(-500);
        @(negedge slowclk);
        check("rst_mid", got1, '0);
        reset_n = 1'b1; sv1 = 1'b0;
        last1 = '0;
        for (int i = 0; i < 3; i++)
            run_vec(mk(500, -500, 0, 0, 0, 0, 0, 0, 0), 1'b0, $sformatf("rst_warm[%0d]", i));
        run_vec(mk(500, -500, 1, 500, 1, 1, -500, 2, 1), 1'b0, "rst_full");

        // Six back-to-back samples: out_valid must follow two cycles later, unbroken.
        for (int i = 0; i < 9; i++) begin
            if (i == 1 || i == 8) check($sformatf("b2b_idle[%0d]", i), got1, {1'b0, last1[39:0]});
            if (i >= 2 && i <= 7) begin
                check($sformatf("b2b[%0d]", i - 2), got1, pack(bb[i-2]));
                last1 = pack(bb[i-2]);
            end
            if (i < 6) begin sv1 = 1'b1; x1 = bb[i].x; y1 = bb[i].y; end
            else sv1 = 1'b0;
            @(negedge slowclk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
